i2s_rx_multi: RTL and testbench



---
 rtl/i2s_rx_multi.sv | 199 +++++++++++++++++++
 tb/tb_i2s_rx_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_multi.sv
// I2S master receiver: generates the bit clock and word select, captures Philips-format mono or
// stereo words, decimates, truncates and queues tagged samples in a FWFT FIFO behind valid/ready.
module i2s_rx_multi #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned I2S_CLK_FREQ  = 1_500_000,
    parameter int unsigned DATA_SIZE     = 24,
    parameter int unsigned SLOT_WIDTH    = 32,
    parameter int unsigned STEREO        = 1,
    parameter int unsigned REDUCE_FACTOR = 1,
    parameter int unsigned OUT_WIDTH     = 16,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic                          i2s_clk,
    output logic                          i2s_ws,
    input  logic                          i2s_sd,
    output logic [OUT_WIDTH-1:0]          m_data,
    output logic                          m_chan,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_count,
    output logic                          busy
);

    localparam int unsigned HALF  = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam int unsigned FRM_W = (REDUCE_FACTOR > 1) ? $clog2(REDUCE_FACTOR) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT       = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] DATA_POS   = BIT_W'(DATA_SIZE);
    localparam logic [BIT_W-1:0] OUT_POS    = BIT_W'(OUT_WIDTH);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(REDUCE_FACTOR - 1);
    localparam logic [AW:0]      LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    if (HALF < 2) begin : g_chk_half
        $error("i2s_rx_multi: CLK_FREQ/(2*I2S_CLK_FREQ) must be at least 2");
    end
    if (SLOT_WIDTH < DATA_SIZE + 1) begin : g_chk_slot
        $error("i2s_rx_multi: SLOT_WIDTH must be at least DATA_SIZE+1");
    end
    if (REDUCE_FACTOR < 1) begin : g_chk_reduce
        $error("i2s_rx_multi: REDUCE_FACTOR must be at least 1");
    end
    if (OUT_WIDTH > DATA_SIZE || OUT_WIDTH < 2) begin : g_chk_out
        $error("i2s_rx_multi: OUT_WIDTH must lie in 2..DATA_SIZE");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("i2s_rx_multi: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 sck_q, sck_d;
    logic                 ws_q, ws_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRM_W-1:0]     frm_q, frm_d;
    logic [OUT_WIDTH-1:0] sh_q, sh_d;
    logic                 drop_right_q, drop_right_d;
    logic                 busy_q;

    logic [BIT_W-1:0]     pos;
    logic [OUT_WIDTH-1:0] shift_in, sample;
    logic                 tick, rise, fall, word_done, push_req, push, drop, pop, full;

    logic [OUT_WIDTH:0]   mem [FIFO_DEPTH];
    logic [OUT_WIDTH:0]   head;
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          level_q;
    logic [15:0]          ovf_q;

    always_comb begin
        tick      = enable && (div_q == DIV_LAST);
        rise      = tick && !sck_q;
        fall      = tick && sck_q;
        pos       = (bit_q >= SLOT) ? bit_q - SLOT : bit_q;
        // Only the first OUT_WIDTH data bits survive truncation, so only those are kept.
        shift_in  = {sh_q[OUT_WIDTH-2:0], i2s_sd};
        sample    = (OUT_WIDTH == DATA_SIZE) ? shift_in : sh_q;
        word_done = rise && (pos == DATA_POS);
        push_req  = word_done && (frm_q == '0) && ((STEREO != 0) || !ws_q);
        pop       = m_valid && m_ready;
        full      = (level_q == LEVEL_FULL);
        // A right word whose left partner was dropped is discarded to keep frames whole.
        drop      = push_req && ((ws_q && drop_right_q) || (full && !pop));
        push      = push_req && !drop;
    end

    always_comb begin
        div_d        = div_q;
        sck_d        = sck_q;
        ws_d         = ws_q;
        bit_d        = bit_q;
        frm_d        = frm_q;
        sh_d         = sh_q;
        drop_right_d = drop_right_q;
        if (!enable) begin
            div_d        = '0;
            sck_d        = 1'b0;
            ws_d         = 1'b0;
            bit_d        = '0;
            frm_d        = '0;
            sh_d         = '0;
            drop_right_d = 1'b0;
        end else begin
            if (tick) begin
                div_d = '0;
                sck_d = !sck_q;
            end else begin
                div_d = div_q + 1'b1;
            end
            if (fall) begin
                bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
                ws_d  = (bit_d >= SLOT);
                if (bit_q == BIT_LAST) begin
                    frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + 1'b1;
                end
            end
            if (rise && (pos >= BIT_W'(1)) && (pos <= OUT_POS)) begin
                sh_d = shift_in;
            end
            if (push_req) begin
                drop_right_d = (STEREO != 0) && !ws_q && drop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            bit_q        <= '0;
            frm_q        <= '0;
            sh_q         <= '0;
            drop_right_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            div_q        <= div_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            bit_q        <= bit_d;
            frm_q        <= frm_d;
            sh_q         <= sh_d;
            drop_right_q <= drop_right_d;
            busy_q       <= enable;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end
    end

    // Push into a full FIFO only happens alongside a pop, so overwriting the head slot is safe.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= {ws_q, sample};
        end
    end

    always_comb begin
        head    = mem[rd_q];
        m_valid = (level_q != '0);
        m_data  = m_valid ? head[OUT_WIDTH-1:0] : '0;
        m_chan  = m_valid && head[OUT_WIDTH];
    end

    assign i2s_clk        = sck_q;
    assign i2s_ws         = ws_q;
    assign busy           = busy_q;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Directed bench for i2s_rx_multi: a stereo depth-4 instance and a mono decimating instance,
// each fed by a small I2S microphone model that counts bit-clock falls on its own.
module tb_i2s_rx_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Instance A: stereo, no decimation, 4-entry FIFO.
    logic        a_en, a_sck, a_ws, a_sd, a_ready, a_valid, a_chan, a_busy;
    logic [15:0] a_data, a_ovf;
    logic [2:0]  a_level;
    logic [23:0] a_l [8];
    logic [23:0] a_r [8];
    logic [5:0]  a_pos = '0;
    int          a_fidx = 0;

    // Instance B: mono, keep one frame in three.
    logic        b_en, b_sck, b_ws, b_sd, b_ready, b_valid, b_chan, b_busy;
    logic [15:0] b_data, b_ovf;
    logic [4:0]  b_level;
    logic [23:0] b_l [8];
    logic [23:0] b_r [8];
    logic [5:0]  b_pos = '0;
    int          b_fidx = 0;

    i2s_rx_multi #(
        .CLK_FREQ(8), .I2S_CLK_FREQ(1), .DATA_SIZE(24), .SLOT_WIDTH(32), .STEREO(1),
        .REDUCE_FACTOR(1), .OUT_WIDTH(16), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(a_en), .i2s_clk(a_sck), .i2s_ws(a_ws), .i2s_sd(a_sd),
        .m_data(a_data), .m_chan(a_chan), .m_valid(a_valid), .m_ready(a_ready),
        .fifo_level(a_level), .overflow_count(a_ovf), .busy(a_busy)
    );

    i2s_rx_multi #(
        .CLK_FREQ(8), .I2S_CLK_FREQ(1), .DATA_SIZE(24), .SLOT_WIDTH(32), .STEREO(0),
        .REDUCE_FACTOR(3), .OUT_WIDTH(16), .FIFO_DEPTH(16)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(b_en), .i2s_clk(b_sck), .i2s_ws(b_ws), .i2s_sd(b_sd),
        .m_data(b_data), .m_chan(b_chan), .m_valid(b_valid), .m_ready(b_ready),
        .fifo_level(b_level), .overflow_count(b_ovf), .busy(b_busy)
    );

    // Microphone models: position 0..63 in the frame, bit p of a slot is word[24-p].
    always @(negedge a_sck or negedge a_en or posedge rst) begin
        if (rst || !a_en) begin
            a_pos  <= '0;
            a_fidx <= 0;
        end else if (a_pos == 6'd63) begin
            a_pos  <= '0;
            a_fidx <= a_fidx + 1;
        end else begin
            a_pos <= a_pos + 6'd1;
        end
    end

    always @(negedge b_sck or negedge b_en or posedge rst) begin
        if (rst || !b_en) begin
            b_pos  <= '0;
            b_fidx <= 0;
        end else if (b_pos == 6'd63) begin
            b_pos  <= '0;
            b_fidx <= b_fidx + 1;
        end else begin
            b_pos <= b_pos + 6'd1;
        end
    end

    logic [23:0] a_word, b_word;
    int          a_p, b_p;
    always_comb begin
        a_word = a_pos[5] ? a_r[a_fidx % 8] : a_l[a_fidx % 8];
        a_p    = int'(a_pos[4:0]);
        a_sd   = (a_p >= 1 && a_p <= 24) ? a_word[24 - a_p] : 1'b0;
        b_word = b_pos[5] ? b_r[b_fidx % 8] : b_l[b_fidx % 8];
        b_p    = int'(b_pos[4:0]);
        b_sd   = (b_p >= 1 && b_p <= 24) ? b_word[24 - b_p] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic goto(input int target);
        step(target - cyc);
    endtask

    int bad;

    initial begin
        rst = 1'b1; a_en = 1'b0; b_en = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        for (int f = 0; f < 8; f++) begin
            a_l[f] = '0; a_r[f] = '0;
            b_l[f] = 24'(f + 1) << 16;
            b_r[f] = 24'hFFFFFF;
        end
        repeat (3) @(negedge clk);
        check("rst_valid", a_valid, 0);
        check("rst_level", a_level, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_sck", a_sck, 0);
        check("rst_ws", a_ws, 0);
        check("rst_busy", a_busy, 0);
        check("rst_data", a_data, 0);
        rst = 1'b0;

        // Stereo pair, consumer always ready.
        a_l[0] = 24'hA5C3F0; a_r[0] = 24'h123456; a_ready = 1'b1;
        @(negedge clk); a_en = 1'b1; cyc = 0;
        goto(3);   check("sck_c3", a_sck, 0);
        goto(4);   check("sck_c4", a_sck, 1); check("busy_on", a_busy, 1);
        goto(8);   check("sck_c8", a_sck, 0);
        goto(12);  check("sck_c12", a_sck, 1);
        goto(195); check("l_not_yet", a_valid, 0);
        goto(196); check("l_valid", a_valid, 1); check("l_data", a_data, 16'hA5C3);
                   check("l_chan", a_chan, 0);
        goto(197); check("l_popped", a_valid, 0);
        goto(255); check("ws_c255", a_ws, 0); check("sck_c255", a_sck, 1);
        goto(256); check("ws_c256", a_ws, 1); check("sck_c256", a_sck, 0);
        goto(451); check("r_not_yet", a_valid, 0);
        goto(452); check("r_valid", a_valid, 1); check("r_data", a_data, 16'h1234);
                   check("r_chan", a_chan, 1);
        goto(453); check("r_popped", a_valid, 0);
        goto(460); a_en = 1'b0; a_ready = 1'b0;

        // Overflow, frame atomicity and push-with-pop on a 4-entry FIFO.
        for (int f = 0; f < 8; f++) begin
            a_l[f] = {8'(16 + f), 16'hC377};
            a_r[f] = {8'(32 + f), 16'h3C11};
        end
        step(2); a_en = 1'b1; cyc = 0;
        goto(963);  check("lvl_3", a_level, 3);
        goto(964);  check("lvl_full", a_level, 4);
        goto(1219); check("ovf_0", a_ovf, 0);
        goto(1220); check("ovf_l2", a_ovf, 1); check("lvl_hold", a_level, 4);
        goto(1476); check("ovf_r2", a_ovf, 2); check("lvl_hold2", a_level, 4);
        a_ready = 1'b1;
        check("drain0", {a_chan, a_data}, 17'h010C3);
        step(1); check("drain1", {a_chan, a_data}, 17'h1203C);
        step(1); check("drain2", {a_chan, a_data}, 17'h011C3);
        step(1); check("drain3", {a_chan, a_data}, 17'h1213C);
        step(1); check("drain_empty", a_valid, 0);
        a_ready = 1'b0;
        goto(2500); check("refill", a_level, 4);
        goto(2756); check("ovf_l5", a_ovf, 3);
        goto(2800); a_ready = 1'b1;
        goto(2801); a_ready = 1'b0; check("lvl_after_pop", a_level, 3);
        goto(3012); check("atomic_ovf", a_ovf, 4); check("atomic_lvl", a_level, 3);
        goto(3268); check("l6_pushed", a_level, 4);
        goto(3523); a_ready = 1'b1;
        goto(3524); check("pp_level", a_level, 4); check("pp_ovf", a_ovf, 4);
        check("pp_head", {a_chan, a_data}, 17'h014C3);
        step(1); check("tail1", {a_chan, a_data}, 17'h1243C);
        step(1); check("tail2", {a_chan, a_data}, 17'h016C3);
        step(1); check("tail3", {a_chan, a_data}, 17'h1263C);
        step(1); check("tail_empty", a_valid, 0);
        a_ready = 1'b0;
        step(2); a_en = 1'b0;

        // Abort mid left slot, then restart cleanly.
        a_l[0] = 24'hBEEF12; a_r[0] = 24'h000000;
        step(2); a_en = 1'b1; cyc = 0;
        goto(84); check("abort_sck", a_sck, 1);
        a_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (a_sck !== 1'b0 || a_valid !== 1'b0 || a_ws !== 1'b0) bad++;
        end
        check("disabled_idle", bad, 0);
        check("disabled_busy", a_busy, 0);
        a_en = 1'b1; cyc = 0;
        goto(1);   check("restart_ws", a_ws, 0);
        goto(195); check("restart_early", a_valid, 0);
        goto(196); check("restart_word", {a_chan, a_data}, 17'h0BEEF);
                   check("restart_ovf", a_ovf, 4);

        // Synchronous reset mid-frame.
        goto(300); check("pre_rst_lvl", a_level, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("mid_rst_valid", a_valid, 0);
        check("mid_rst_level", a_level, 0);
        check("mid_rst_data", a_data, 0);
        check("mid_rst_chan", a_chan, 0);
        check("mid_rst_ovf", a_ovf, 0);
        check("mid_rst_sck", a_sck, 0);
        check("mid_rst_ws", a_ws, 0);
        check("mid_rst_busy", a_busy, 0);
        a_en = 1'b0;

        // Mono with decimation by 3: only frames 0 and 3 survive.
        step(2); b_en = 1'b1; cyc = 0;
        goto(196);  check("m_first", {b_chan, b_data}, 17'h00100); check("m_lvl1", b_level, 1);
        goto(256);  check("m_ws_toggles", b_ws, 1);
        goto(1731); check("m_lvl_hold", b_level, 1);
        goto(1732); check("m_lvl2", b_level, 2);
        goto(3072); check("m_lvl_end", b_level, 2); check("m_ovf", b_ovf, 0);
        b_ready = 1'b1;
        check("m_out0", {b_chan, b_data}, 17'h00100);
        step(1); check("m_out1", {b_chan, b_data}, 17'h00400);
        step(1); check("m_empty", b_valid, 0);
        b_ready = 1'b0; b_en = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
